// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared register-file write widths and pending-entry type
package wb_port_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo: circular buffer of pending multi-cycle results with flush
module wb_pending_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB and a buffered multi-cycle unit
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    input  logic                  mdu_flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  stall_req,
    output logic                  collision_err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic          wb_live, push, pop, full, empty;
    wb_entry_t     head;
    logic [CW-1:0] blk;
    assign wb_live   = wb_regwrite && wb_rd != '0;
    assign mdu_ready = !full;
    // rd=0 results are accepted but never stored; flush drops the acceptance
    assign push = mdu_valid && mdu_ready && mdu_rd != '0 && !mdu_flush;
    assign pop  = !wb_live && !empty && !mdu_flush;
    wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(mdu_flush),
        .din  ('{rd: mdu_rd, data: mdu_data}),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            blk           <= '0;
            stall_req     <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            rf_we     <= wb_live || pop;
            rf_waddr  <= wb_live ? wb_rd : pop ? head.rd : '0;
            rf_wdata  <= wb_live ? wb_data : pop ? head.data : '0;
            blk       <= (mdu_flush || pop) ? '0 :
                         (wb_live && !empty && blk != CW'(STARVE_LIMIT)) ? blk + 1'b1 : blk;
            stall_req <= blk == CW'(STARVE_LIMIT) && !pop && !mdu_flush;
            if (wb_live && stall_req) collision_err <= 1'b1;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, pending-result buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, consecutive blocked cycles before stall_req asserts.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wb_regwrite  input  1  pipeline WB stage requests register write.
REQ-006 SHALL have port wb_rd  input  5  pipeline WB destination register.
REQ-007 SHALL have port wb_data  input  32  pipeline WB write data (already MemtoReg-selected).
REQ-008 SHALL have port mdu_valid  input  1  multi-cycle unit offers a result.
REQ-009 SHALL have port mdu_rd  input  5  multi-cycle unit destination register.
REQ-010 SHALL have port mdu_data  input  32  multi-cycle unit result.
REQ-011 SHALL have port mdu_ready  output  1  buffer can accept; equals !full, combinational from state only.
REQ-012 SHALL have port mdu_flush  input  1  discard all buffered multi-cycle results.
REQ-013 SHALL have port rf_we  output  1  registered register-file write enable.
REQ-014 SHALL have port rf_waddr  output  5  registered write address.
REQ-015 SHALL have port rf_wdata  output  32  registered write data.
REQ-016 SHALL have port stall_req  output  1  registered request to hold the pipeline WB stage for one or more cycles.
REQ-017 SHALL have port collision_err  output  1  sticky flag: WB write arrived while stall_req high.

Function
REQ-018 SHALL treat a WB request as live only when wb_regwrite=1 and wb_rd!=0; rd=0 requests neither write nor block.
REQ-019 SHALL accept an MDU result on a cycle with mdu_valid=1 and mdu_ready=1; rd=0 results SHALL be accepted and discarded, not enqueued.
REQ-020 SHALL store accepted results in a DEPTH-entry FIFO of {rd,data}, circular pointers wrapping at DEPTH, with full/empty derived from an occupancy count.
REQ-021 SHALL grant the write port each cycle: live WB first; else FIFO head (pop) if non-empty; else no write.
REQ-022 SHALL present the granted write on rf_we/rf_waddr/rf_wdata one cycle after the grant cycle (latency 1); rf_we=0 on cycles with no grant.
REQ-023 SHALL never bypass the FIFO: an MDU result accepted in cycle N is granted no earlier than cycle N+1.
REQ-024 SHALL allow simultaneous push and pop in one cycle when non-empty, occupancy unchanged; push while full is impossible since mdu_ready=0.
REQ-025 SHALL increment a blocked counter each cycle the FIFO is non-empty and a live WB takes the port, clear it on any pop, and hold it otherwise, saturating at STARVE_LIMIT.
REQ-026 SHALL assert stall_req from the cycle after the counter reaches STARVE_LIMIT until the cycle after the next pop.
REQ-027 SHALL, if a live WB occurs while stall_req=1, still grant WB and set collision_err until reset.
REQ-028 SHALL on mdu_flush=1 empty the FIFO, clear the blocked counter and drop any same-cycle MDU acceptance (flush wins); a same-cycle live WB grant is unaffected.
REQ-029 SHALL preserve arrival order among MDU results.

Reset
REQ-030 SHALL on reset asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, collision_err=0, FIFO empty, pointers and counter 0, so mdu_ready=1 once reset is released.
REQ-031 SHALL on reset mid-operation discard all buffered results without issuing any write.

Structure
REQ-032 SHALL place REG_ADDR_W=5, DATA_W=32 and the {rd,data} entry typedef in the shared processor package.
REQ-033 SHALL implement the buffer as one sub-module, wb_pending_fifo; arbitration, counter and output registers stay in the top module.

Verification
REQ-034 SHALL check: WB rd=8 data=0x11 alone -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x11.
REQ-035 SHALL check: MDU rd=5 data=0xAA with WB idle -> accept at N, rf write of r5=0xAA visible after cycle N+1 grant.
REQ-036 SHALL check: two MDU results (r3=0x1, r4=0x2) under continuous live WB -> mdu_ready=0 after two pushes, stall_req=1 after 3 blocked cycles, WB drops -> writes r3 then r4, stall_req clears.
REQ-037 SHALL check: mdu_flush coincident with MDU push of r6 while one entry buffered -> no MDU write ever issued, mdu_ready=1 next cycle.
REQ-038 SHALL check: WB rd=0 and MDU rd=0 -> no rf write, FIFO stays empty; live WB during stall_req -> collision_err=1 and stays set.
REQ-039 SHALL check: reset asserted with two entries buffered -> all outputs 0 immediately, no buffered write after release.
